// File: rtl/rv32i_types.sv
// Shared cache-system types: a 256-bit cache line and its 27-bit line tag.
// line_addr rebuilds the line-aligned byte address from a tag.
package rv32i_types;
  typedef logic [255:0] cacheline_t;
  typedef logic [26:0]  line_tag_t;

  localparam int unsigned LINE_OFFSET_W = 5;

  function automatic logic [31:0] line_addr(input line_tag_t tag);
    return {tag, {LINE_OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/wb_buffer_entries.sv
// Circular store of pending write-back lines.
// Provides a combinational tag lookup, plus push, in-place overwrite and head pop.
module wb_buffer_entries
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  line_tag_t     lookup_tag,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output cacheline_t    hit_line,
  input  logic          push,
  input  line_tag_t     push_tag,
  input  cacheline_t    push_line,
  input  logic          overwrite,
  input  logic [IW-1:0] overwrite_idx,
  input  cacheline_t    overwrite_line,
  input  logic          pop,
  output line_tag_t     head_tag,
  output cacheline_t    head_line,
  output logic [CW-1:0] count,
  output logic          full
);
  logic [DEPTH-1:0] valid;
  line_tag_t        tags  [DEPTH];
  cacheline_t       lines [DEPTH];
  logic [IW-1:0]    head;
  logic [IW-1:0]    tail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[tail]  <= push_tag;
      lines[tail] <= push_line;
    end
    if (overwrite) begin
      lines[overwrite_idx] <= overwrite_line;
    end
  end

  // Writes coalesce, so at most one valid entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (tags[i] == lookup_tag)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign hit_line  = lines[hit_idx];
  assign head_tag  = tags[head];
  assign head_line = lines[head];
  assign full      = (count == CW'(DEPTH));
endmodule

// File: rtl/l2_writeback_buffer.sv
// Write-back buffer between L2 and the cacheline adaptor: one-cycle eviction
// acceptance, background drain when idle, and coherent read-after-evict.
module l2_writeback_buffer
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            mem_address,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [255:0]           mem_wdata256,
  output logic [255:0]           mem_rdata256,
  output logic                   mem_resp,
  output logic [31:0]            pmem_address,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [255:0]           pmem_wdata,
  input  logic [255:0]           pmem_rdata,
  input  logic                   pmem_resp,
  output logic [$clog2(DEPTH):0] wb_count
);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, RESP, MEMRD, DRAIN, FDRAIN} state_t;

  state_t                 state;
  line_tag_t              req_tag;
  line_tag_t              rd_tag;
  logic                   hit;
  logic [IW-1:0]          hit_idx;
  cacheline_t             hit_line;
  line_tag_t              head_tag;
  cacheline_t             head_line;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   push;
  logic                   overwrite;
  logic                   pop;
  logic                   draining;
  logic                   unused_offset;

  assign req_tag       = mem_address[31:5];
  assign unused_offset = ^mem_address[4:0];
  assign draining      = (state == DRAIN) || (state == FDRAIN);

  // Read wins over write when both are (illegally) raised together.
  assign push      = (state == IDLE) && !mem_read && mem_write && !hit && !full;
  assign overwrite = (state == IDLE) && !mem_read && mem_write && hit;
  assign pop       = draining && pmem_resp;

  wb_buffer_entries #(.DEPTH(DEPTH)) u_entries (
    .clk            (clk),
    .reset_n        (reset_n),
    .lookup_tag     (req_tag),
    .hit            (hit),
    .hit_idx        (hit_idx),
    .hit_line       (hit_line),
    .push           (push),
    .push_tag       (req_tag),
    .push_line      (mem_wdata256),
    .overwrite      (overwrite),
    .overwrite_idx  (hit_idx),
    .overwrite_line (mem_wdata256),
    .pop            (pop),
    .head_tag       (head_tag),
    .head_line      (head_line),
    .count          (count),
    .full           (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem_rdata256 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read) begin
            if (hit) begin
              mem_rdata256 <= hit_line;
              state        <= RESP;
            end else begin
              state <= MEMRD;
            end
          end else if (mem_write) begin
            state <= (hit || !full) ? RESP : FDRAIN;
          end else if (count != '0) begin
            state <= DRAIN;
          end
        end
        RESP: state <= IDLE;
        MEMRD: begin
          if (pmem_resp) begin
            mem_rdata256 <= pmem_rdata;
            state        <= RESP;
          end
        end
        DRAIN, FDRAIN: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && mem_read) rd_tag <= req_tag;
  end

  assign mem_resp   = (state == RESP);
  assign pmem_read  = (state == MEMRD);
  assign pmem_write = draining;
  assign pmem_wdata = draining ? head_line : '0;
  assign wb_count   = count;

  always_comb begin
    pmem_address = '0;
    if (state == MEMRD)  pmem_address = line_addr(rd_tag);
    else if (draining)   pmem_address = line_addr(head_tag);
  end
endmodule

// File: doc/l2_writeback_buffer.md
# l2_writeback_buffer

Write-back buffer between `l2_cache` and `cacheline_adaptor` in `cache_sys`.
- Absorbs 256-bit dirty-line evictions from L2 and acknowledges them in one cycle.
- Drains them to memory when the downstream port is idle.
- Serves L2 read misses, from a buffered copy if the line is pending or from memory otherwise.
- L2 eviction stalls shrink from a full DRAM burst write to one cycle; read-after-evict to the same line stays coherent.

## Interface
Parameters:
- `DEPTH`, 4, number of line entries; power of 2, ≥2.

Ports:
- `clk` in 1: single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_address` in 32: L2 request address; bits [4:0] ignored.
- `mem_read` in 1: L2 line read, held until `mem_resp`.
- `mem_write` in 1: L2 line write-back, held until `mem_resp`.
- `mem_wdata256` in 256: write-back line.
- `mem_rdata256` out 256: read line, valid while `mem_resp`=1.
- `mem_resp` out 1: one-cycle completion pulse.
- `pmem_address` out 32: line-aligned address, [4:0]=0.
- `pmem_read` out 1: adaptor read, held until `pmem_resp`.
- `pmem_write` out 1: adaptor write, held until `pmem_resp`.
- `pmem_wdata` out 256: line to adaptor.
- `pmem_rdata` in 256: line from adaptor, valid with `pmem_resp`.
- `pmem_resp` in 1: adaptor completion pulse.
- `wb_count` out $clog2(DEPTH)+1: valid-entry count, for perf counters.

## Operation
- Storage: circular FIFO of {tag[31:5], line[255:0]} entries with head/tail pointers and count.
  - Tags are unique, because writes coalesce.
- FSM states: IDLE, RESP, MEMRD, DRAIN, FDRAIN.
- IDLE priority: read > write > background drain.
  - `mem_read`, tag hits entry: latch entry line into `mem_rdata256` → RESP.
  - `mem_read`, miss: latch address → MEMRD.
  - `mem_write`, tag hits entry: overwrite that entry's line in place; count unchanged → RESP. This applies even when full.
  - `mem_write`, miss, not full: write at tail, tail++, count++ → RESP.
  - `mem_write`, miss, full → FDRAIN.
  - No request, count>0 → DRAIN.
- MEMRD: `pmem_read`=1, `pmem_address`={latched tag,5'b0}. On `pmem_resp`: capture `pmem_rdata` → RESP.
- DRAIN/FDRAIN: `pmem_write`=1, address/data from head entry. On `pmem_resp`: invalidate head, head++, count-- → IDLE.
  - From FDRAIN the pending write is then accepted normally.
- RESP: `mem_resp`=1 for exactly one cycle; requests ignored → IDLE.
- A read arriving during DRAIN waits for drain completion; downstream transactions are never aborted.
- Simultaneous `mem_read`&`mem_write` is illegal; read is served and write ignored.
- Pointers wrap modulo DEPTH; count saturates logically at DEPTH (full) and 0 (empty).

## Timing
- Reset (async, `reset_n`=0):
  - State IDLE; all entries invalid; head=tail=count=0.
  - `mem_resp`=0, `mem_rdata256`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0 immediately.
  - Reset mid-DRAIN/MEMRD discards the transaction and buffered lines (adaptor shares reset).
- `pmem_*` outputs are decoded from state and registered entry data; they are 0 outside MEMRD/DRAIN/FDRAIN.
- Write accepted at IDLE cycle t: `mem_resp` at t+1.
- Buffered read hit at t: `mem_resp` at t+1 with line.
- Read miss at t:
  - `pmem_read` from t+1.
  - `pmem_resp` at cycle k → `mem_resp` at k+1.
  - `pmem_read` low at k+1.
- Full-buffer write at t: `pmem_write` from t+1; `pmem_resp` at k; accept at k+1; `mem_resp` at k+2.
- Background drain starts the cycle after IDLE with no request.
- Next request is sampled in IDLE one cycle after RESP; L2 deasserts by then.

## Structure
- `rv32i_types` gains `cacheline_t` (logic [255:0]) and `line_tag_t` (logic [26:0]).
- FSM state enum stays local to the module.
- One sub-module, `wb_buffer_entries`:
  - valid/tag/line arrays, head/tail/count;
  - combinational tag-match (hit, index);
  - push, overwrite, and pop ports.
- `l2_writeback_buffer` keeps the FSM and output muxing.

## Test plan
- Write 0x1000_0040 (line A) → `mem_resp` next cycle; idle → `pmem_write`, address 0x1000_0040, data A; after `pmem_resp`, `wb_count`=0.
- Write line B to 0x2000_0000, then read 0x2000_0004 before drain → `mem_resp` 1 cycle later, `mem_rdata256`=B, no `pmem_read`.
- Write 0x3000_0000 twice (C then D) with stalled adaptor → `wb_count`=1; drain writes D only.
- Fill 4 entries with adaptor stalled, then write 5th → one `pmem_write` of oldest entry, then 5th accepted, `mem_resp` at `pmem_resp`+2, `wb_count`=4.
- Read miss 0x4000_0020 → `pmem_read` at t+1, address 0x4000_0020; `pmem_resp` with E → `mem_resp` next cycle, data E.
- Assert `reset_n`=0 mid-DRAIN → `pmem_write`=0 same cycle, `wb_count`=0; post-reset read of that address goes to memory.
